// File: rtl/rsr_sequencer_if.sv
// Pipeline-side handshake for the RSR sequencer: Decode/Execute controls in,
// hold/cycle indicators, gated write enable and NZCV flags out.
interface rsr_sequencer_if;
    logic       validD;
    logic       RselectD;
    logic       stallE;
    logic       flushE;
    logic       RegWriteE;
    logic       FlagWriteE;
    logic       doNotWriteRegE;
    logic [3:0] ALUFlagsE;
    logic       holdFDE;
    logic       prevRSRstateE;
    logic       RSRcycle1E;
    logic       RegWriteGatedE;
    logic [3:0] Flags;
    logic [1:0] previousCVflag;

    modport master (
        output validD, RselectD, stallE, flushE, RegWriteE, FlagWriteE,
               doNotWriteRegE, ALUFlagsE,
        input  holdFDE, prevRSRstateE, RSRcycle1E, RegWriteGatedE, Flags,
               previousCVflag
    );

    modport slave (
        input  validD, RselectD, stallE, flushE, RegWriteE, FlagWriteE,
               doNotWriteRegE, ALUFlagsE,
        output holdFDE, prevRSRstateE, RSRcycle1E, RegWriteGatedE, Flags,
               previousCVflag
    );
endinterface

// File: rtl/rsr_sequencer.sv
// Stretches register-shifted-register ops over two Execute cycles and owns the
// NZCV flag register. The sequencing FSM is built only when LEG_RSR_SEQ_EN is defined.
module rsr_sequencer (
    input  logic           clk,
    input  logic           reset,
    rsr_sequencer_if.slave bus
);
    logic       rsr_cycle1;
    logic [3:0] flags_q;

`ifdef LEG_RSR_SEQ_EN
    typedef enum logic [1:0] {IDLE, RSR1, RSR2} state_t;

    state_t state;
    logic   start_rsr;

    assign start_rsr = bus.validD & bus.RselectD & ~bus.stallE & ~bus.flushE;

    // NOTE: state is sequential, so only non-blocking assignments are used here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (bus.flushE) begin
            state <= IDLE;
        end else if (!bus.stallE) begin
            case (state)
                IDLE, RSR2: state <= start_rsr ? RSR1 : IDLE;
                RSR1:       state <= RSR2;
                default:    state <= IDLE;
            endcase
        end
    end

    assign rsr_cycle1        = (state == RSR1);
    assign bus.holdFDE       = rsr_cycle1;
    assign bus.RSRcycle1E    = rsr_cycle1;
    assign bus.prevRSRstateE = (state == RSR2);
`else
    logic unused_decode;

    // Without the sequencer every op is single-cycle; the RSR decode is ignored.
    assign unused_decode     = bus.validD ^ bus.RselectD;
    assign rsr_cycle1        = 1'b0;
    assign bus.holdFDE       = 1'b0;
    assign bus.RSRcycle1E    = 1'b0;
    assign bus.prevRSRstateE = 1'b0;
`endif

    // The first RSR cycle only reads the shift amount, so it never commits flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (bus.FlagWriteE & ~rsr_cycle1 & ~bus.stallE & ~bus.flushE) begin
            flags_q <= bus.ALUFlagsE;
        end
    end

    assign bus.RegWriteGatedE = bus.RegWriteE & ~bus.doNotWriteRegE & ~rsr_cycle1 & ~bus.flushE;
    assign bus.Flags          = flags_q;
    assign bus.previousCVflag = flags_q[1:0];
endmodule

// File: doc/rsr_sequencer.md
RSR_SEQUENCER -- requirements
Module: rsr_sequencer

Interface
REQ-001 Parameter: none; the block has no parameters.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 validD  input  1  Decode holds a valid instruction.
REQ-006 RselectD  input  1  Decode instruction is a register-shifted-register (RSR) data-processing op.
REQ-007 stallE  input  1  external hazard stall; freezes Execute this cycle.
REQ-008 flushE  input  1  Execute flush (branch/exception).
REQ-009 RegWriteE  input  1  Execute instruction requests register write, with condition passed.
REQ-010 FlagWriteE  input  1  Execute instruction sets flags (S bit, condition passed).
REQ-011 doNotWriteRegE  input  1  ALU reports TST/TEQ/CMP/CMN.
REQ-012 ALUFlagsE  input  4  ALU result flags, NZCV order.
REQ-013 holdFDE  output  1  hold Fetch, Decode and Execute pipeline registers.
REQ-014 prevRSRstateE  output  1  Execute is in RSR second cycle; selects cycle-2 shifter carry.
REQ-015 RSRcycle1E  output  1  Execute is in RSR first cycle (shift-amount read).
REQ-016 RegWriteGatedE  output  1  qualified register write enable.
REQ-017 Flags  output  4  architectural NZCV register.
REQ-018 previousCVflag  output  2  [1]=C, [0]=V from Flags, fed back to the ALU.

Function
REQ-019 FSM states: IDLE, RSR1, RSR2; state register updates only on rising clk.
REQ-020 IDLE->RSR1 when validD & RselectD & ~stallE & ~flushE; otherwise stay IDLE.
REQ-021 RSR1->RSR2 when ~stallE & ~flushE; stay RSR1 when stallE & ~flushE.
REQ-022 RSR2->RSR1 when next-D RSR condition (REQ-020) holds and ~stallE; ->IDLE when ~stallE otherwise; stay RSR2 when stallE.
REQ-023 flushE in any state forces IDLE next cycle, overriding stallE.
REQ-024 holdFDE = 1 exactly when state==RSR1; combinational from state; one extra cycle per RSR op.
REQ-025 RSRcycle1E = (state==RSR1); prevRSRstateE = (state==RSR2).
REQ-026 RegWriteGatedE = RegWriteE & ~doNotWriteRegE & ~RSRcycle1E & ~flushE; combinational.
REQ-027 Flags <= ALUFlagsE at clock edge when FlagWriteE & ~RSRcycle1E & ~stallE & ~flushE; else hold.
REQ-028 previousCVflag = Flags[1:0]; registered value only, no same-cycle bypass (no ALU loop).
REQ-029 Non-RSR instructions: state stays IDLE, zero added latency, outputs pass through per REQ-026/027.

Reset
REQ-030 reset forces state=IDLE, Flags=4'b0000 next edge; thus holdFDE=0, RSRcycle1E=0, prevRSRstateE=0, previousCVflag=2'b00.
REQ-031 reset asserted mid-RSR (RSR1 or RSR2) aborts the sequence; no flag update on that edge.
REQ-032 reset has priority over flushE, stallE and all transitions.

Configuration
REQ-033 Macro LEG_RSR_SEQ_EN: when defined, FSM and REQ-019..025 as specified.
REQ-034 Without LEG_RSR_SEQ_EN: no FSM; holdFDE, RSRcycle1E, prevRSRstateE tied 0; RselectD ignored; flag and RegWrite logic unchanged.

Verification
REQ-035 Reset then RSR in D (validD=1, RselectD=1) -> next cycle holdFDE=1, RSRcycle1E=1; following cycle prevRSRstateE=1, holdFDE=0.
REQ-036 RSR with FlagWriteE=1, ALUFlagsE=4'b0110 -> Flags unchanged in RSR1, Flags=4'b0110 after RSR2 edge, previousCVflag=2'b10.
REQ-037 Back-to-back RSR ops -> state sequence RSR1,RSR2,RSR1,RSR2,IDLE; holdFDE pattern 1,0,1,0,0.
REQ-038 stallE=1 for 3 cycles in RSR1 -> state stays RSR1, holdFDE=1 throughout, Flags unchanged; release -> RSR2.
REQ-039 flushE=1 in RSR1 with FlagWriteE=1 -> state IDLE next cycle, Flags unchanged, RegWriteGatedE=0.
REQ-040 CMP (doNotWriteRegE=1, RegWriteE=1, FlagWriteE=1, ALUFlagsE=4'b0100) -> RegWriteGatedE=0, Flags=4'b0100 next cycle.
